cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the 10-bit processor datapath. It sequences the 4-entry register file (ENW/WRA write port, ENR0/RDA0 and ENR1/RDA1 read ports), the ALU operand/result registers and the bus drivers. Each instruction is accepted from the data bus on an EXEC request, executed over 1–3 cycles, and completed with a one-cycle DONE pulse. It sits between the external instruction source and the register file / ALU.

---
 rtl/cpu_sequencer.sv | 111 +++++++++++
 tb/tb_cpu_sequencer.sv | 104 ++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM that steps the register file, ALU and bus drivers
// through LOAD, COPY and two-operand ALU instructions, one DONE pulse per instruction.
module cpu_sequencer (
  input  logic       CLKb,
  input  logic       RSTb,
  input  logic       EXEC,
  input  logic [9:0] D,
  output logic       ENW,
  output logic [1:0] WRA,
  output logic       ENR0,
  output logic [1:0] RDA0,
  output logic       ENR1,
  output logic [1:0] RDA1,
  output logic       EXT,
  output logic       LDA,
  output logic       LDG,
  output logic       OUTG,
  output logic [2:0] FN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ILL
);
  typedef enum logic [2:0] {IDLE, T1, T2, T3, DN} state_t;
  state_t state_q, state_d;
  logic [9:0] ir_q, ir_d;
  logic [1:0] rx, ry;
  logic [3:0] op;
  logic alu_op, ir_unused;
  assign rx = ir_q[9:8];
  assign ry = ir_q[7:6];
  assign op = ir_q[3:0];
  assign ir_unused = ^ir_q[5:4];
  assign alu_op = (op >= 4'd2) && (op <= 4'd6);
  always_ff @(posedge CLKb) begin
    if (!RSTb) begin
      state_q <= IDLE;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    ENW = 1'b0;
    WRA = 2'd0;
    ENR0 = 1'b0;
    RDA0 = 2'd0;
    ENR1 = 1'b0;
    RDA1 = 2'd0;
    EXT = 1'b0;
    LDA = 1'b0;
    LDG = 1'b0;
    OUTG = 1'b0;
    FN = 3'd0;
    DONE = 1'b0;
    ILL = 1'b0;
    BUSY = state_q != IDLE;
    case (state_q)
      IDLE: if (EXEC) begin
        ir_d = D;
        state_d = T1;
      end
      T1: begin
        if (op == 4'd0) begin
          EXT = 1'b1;
          ENW = 1'b1;
          WRA = rx;
          state_d = DN;
        end else if (op == 4'd1) begin
          ENR0 = 1'b1;
          RDA0 = ry;
          ENW = 1'b1;
          WRA = rx;
          state_d = DN;
        end else if (alu_op) begin
          ENR0 = 1'b1;
          RDA0 = rx;
          LDA = 1'b1;
          state_d = T2;
        end else begin
          ILL = 1'b1;
          state_d = DN;
        end
      end
      T2: begin
        ENR1 = 1'b1;
        RDA1 = ry;
        FN = op[2:0] - 3'd2;
        LDG = 1'b1;
        state_d = T3;
      end
      T3: begin
        OUTG = 1'b1;
        ENW = 1'b1;
        WRA = rx;
        state_d = DN;
      end
      DN: begin
        DONE = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // reset overrides the decode so an interrupted instruction cannot write
    if (!RSTb) begin
      {ENW, WRA, ENR0, RDA0, ENR1, RDA1, EXT, LDA, LDG, OUTG, FN, BUSY, DONE, ILL} = '0;
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed cycle-by-cycle check of cpu_sequencer outputs via an expected-value queue.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic RSTb = 1'b0, EXEC = 1'b0;
  logic [9:0] D = '0;
  logic ENW, ENR0, ENR1, EXT, LDA, LDG, OUTG, BUSY, DONE, ILL;
  logic [1:0] WRA, RDA0, RDA1;
  logic [2:0] FN;
  logic [18:0] exp_q[$];
  int checks = 0, fails = 0;

  cpu_sequencer dut (
    .CLKb(clk), .RSTb(RSTb), .EXEC(EXEC), .D(D),
    .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
    .EXT(EXT), .LDA(LDA), .LDG(LDG), .OUTG(OUTG), .FN(FN),
    .BUSY(BUSY), .DONE(DONE), .ILL(ILL)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] ov(input logic busy, done, ill, enw, input logic [1:0] wra,
                                     input logic enr0, input logic [1:0] rda0,
                                     input logic enr1, input logic [1:0] rda1,
                                     input logic ext, lda, ldg, outg, input logic [2:0] fn);
    return {busy, done, ill, enw, wra, enr0, rda0, enr1, rda1, ext, lda, ldg, outg, fn};
  endfunction

  task automatic cyc(input logic rstb, exec, input logic [9:0] d, input logic [18:0] e, input string tag);
    logic [18:0] obs, want;
    @(negedge clk);
    RSTb = rstb;
    EXEC = exec;
    D = d;
    exp_q.push_back(e);
    #1;
    obs = {BUSY, DONE, ILL, ENW, WRA, ENR0, RDA0, ENR1, RDA1, EXT, LDA, LDG, OUTG, FN};
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  localparam logic [18:0] Z = '0;
  localparam logic [18:0] DNV = 19'b110_0000000000000000;

  initial begin
    cyc(0, 1, 10'h100, Z, "rst0");
    cyc(0, 1, 10'h100, Z, "rst1");
    cyc(1, 1, 10'h100, Z, "load_accept");
    cyc(1, 0, 10'h155, ov(1,0,0,1,2'b01,0,0,0,0,1,0,0,0,0), "load_t1");
    cyc(1, 0, 10'h000, DNV, "load_dn");
    cyc(1, 1, 10'h241, Z, "copy_accept");
    cyc(1, 0, 10'h000, ov(1,0,0,1,2'b10,1,2'b01,0,0,0,0,0,0,0), "copy_t1");
    cyc(1, 0, 10'h000, DNV, "copy_dn");
    cyc(1, 1, 10'h382, Z, "add_accept");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,1,2'b11,0,0,0,1,0,0,0), "add_t1");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,0,0,1,2'b10,0,0,1,0,3'b000), "add_t2");
    cyc(1, 0, 10'h000, ov(1,0,0,1,2'b11,0,0,0,0,0,0,0,1,0), "add_t3");
    cyc(1, 0, 10'h000, DNV, "add_dn");
    cyc(1, 1, 10'h38A, Z, "ill_accept");
    cyc(1, 0, 10'h000, ov(1,0,1,0,0,0,0,0,0,0,0,0,0,0), "ill_t1");
    cyc(1, 0, 10'h000, DNV, "ill_dn");
    cyc(1, 0, 10'h000, Z, "ill_idle");
    cyc(1, 1, 10'h043, Z, "sub1_accept");
    cyc(1, 1, 10'h183, ov(1,0,0,0,0,1,2'b00,0,0,0,1,0,0,0), "sub1_t1");
    cyc(1, 1, 10'h183, ov(1,0,0,0,0,0,0,1,2'b01,0,0,1,0,3'b001), "sub1_t2");
    cyc(1, 1, 10'h183, ov(1,0,0,1,2'b00,0,0,0,0,0,0,0,1,0), "sub1_t3");
    cyc(1, 1, 10'h183, DNV, "sub1_dn");
    cyc(1, 1, 10'h183, Z, "sub2_gap_idle");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,1,2'b01,0,0,0,1,0,0,0), "sub2_t1");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,0,0,1,2'b10,0,0,1,0,3'b001), "sub2_t2");
    cyc(1, 0, 10'h000, ov(1,0,0,1,2'b01,0,0,0,0,0,0,0,1,0), "sub2_t3");
    cyc(1, 0, 10'h000, DNV, "sub2_dn");
    cyc(1, 1, 10'h005, Z, "or_accept");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,1,2'b00,0,0,0,1,0,0,0), "or_t1");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,0,0,1,2'b00,0,0,1,0,3'b011), "or_t2");
    cyc(1, 0, 10'h000, ov(1,0,0,1,2'b00,0,0,0,0,0,0,0,1,0), "or_t3");
    cyc(1, 0, 10'h000, DNV, "or_dn");
    cyc(1, 1, 10'h1C4, Z, "and_accept");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,1,2'b01,0,0,0,1,0,0,0), "and_t1");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,0,0,1,2'b11,0,0,1,0,3'b010), "and_t2");
    cyc(1, 0, 10'h000, ov(1,0,0,1,2'b01,0,0,0,0,0,0,0,1,0), "and_t3");
    cyc(1, 0, 10'h000, DNV, "and_dn");
    cyc(1, 1, 10'h007, Z, "ill7_accept");
    cyc(1, 0, 10'h000, ov(1,0,1,0,0,0,0,0,0,0,0,0,0,0), "ill7_t1");
    cyc(1, 0, 10'h000, DNV, "ill7_dn");
    cyc(1, 1, 10'h2C6, Z, "xor_accept");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,1,2'b10,0,0,0,1,0,0,0), "xor_t1");
    cyc(1, 0, 10'h000, ov(1,0,0,0,0,0,0,1,2'b11,0,0,1,0,3'b100), "xor_t2");
    cyc(0, 0, 10'h000, Z, "xor_t3_reset");
    cyc(1, 0, 10'h000, Z, "post_reset_idle");
    cyc(1, 0, 10'h000, Z, "post_reset_no_done");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
